// File: rtl/mmio_pkg.sv
// Shared types and the default SoC address map for the MMIO router.
// Map entries are base/mask pairs so they plug straight into SLV_BASE/SLV_MASK.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int TIMER_W = 8;
  localparam int MAP_AW  = 32;

  // Region lengths are powers of two, so the match mask is the inverted length-1.
  function automatic logic [MAP_AW-1:0] len_to_mask(input logic [MAP_AW-1:0] len);
    return ~(len - MAP_AW'(1));
  endfunction

  localparam logic [MAP_AW-1:0] ADDR_RAM = 32'h8000_0000;
  localparam logic [MAP_AW-1:0] RAM_LEN  = 32'h0800_0000;
  localparam logic [MAP_AW-1:0] RAM_MASK = len_to_mask(RAM_LEN);

  localparam logic [MAP_AW-1:0] KBD_ADDR = 32'hA000_0000;
  localparam logic [MAP_AW-1:0] KBD_LEN  = 32'h0000_1000;
  localparam logic [MAP_AW-1:0] KBD_MASK = len_to_mask(KBD_LEN);

  localparam logic [MAP_AW-1:0] PERI_LEN  = 32'h0000_1000;
  localparam logic [MAP_AW-1:0] PERI_MASK = len_to_mask(PERI_LEN);
  localparam logic [MAP_AW-1:0] SWT_ADDR  = 32'hA000_1000;
  localparam logic [MAP_AW-1:0] SEG_ADDR  = 32'hA000_2000;
  localparam logic [MAP_AW-1:0] LED_ADDR  = 32'hA000_3000;

  localparam logic [MAP_AW-1:0] RTC_ADDR = 32'hA000_4000;
  localparam logic [MAP_AW-1:0] RTC_LEN  = 32'h0000_1000;
  localparam logic [MAP_AW-1:0] RTC_MASK = len_to_mask(RTC_LEN);

  localparam int DEF_N_SLV = 6;
  localparam logic [DEF_N_SLV*MAP_AW-1:0] DEF_SLV_BASE =
    {RTC_ADDR, LED_ADDR, SEG_ADDR, SWT_ADDR, KBD_ADDR, ADDR_RAM};
  localparam logic [DEF_N_SLV*MAP_AW-1:0] DEF_SLV_MASK =
    {RTC_MASK, PERI_MASK, PERI_MASK, PERI_MASK, KBD_MASK, RAM_MASK};

endpackage

// File: rtl/mmio_addr_dec.sv
// Combinational priority address decoder: lowest matching slave index wins.
module mmio_addr_dec
  import mmio_pkg::*;
#(
  parameter int                        ADDR_W   = 32,
  parameter int                        N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  sel,
  output logic              hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!hit && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                   (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// CPU LSU to N_SLV peripheral router: valid/ready request, one outstanding
// transaction, registered one-cycle response, error on unmapped address or timeout.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int                        ADDR_W   = 32,
  parameter int                        DATA_W   = 64,
  parameter int                        N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0,
  parameter int                        TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic                      cpu_req_wen,
  input  logic [ADDR_W-1:0]         cpu_req_addr,
  input  logic [DATA_W-1:0]         cpu_req_wdata,
  input  logic [DATA_W/8-1:0]       cpu_req_wstrb,
  output logic                      cpu_rsp_valid,
  output logic [DATA_W-1:0]         cpu_rsp_rdata,
  output logic                      cpu_rsp_err,
  output logic [N_SLV-1:0]          slv_req_valid,
  input  logic [N_SLV-1:0]          slv_req_ready,
  output logic                      slv_req_wen,
  output logic [ADDR_W-1:0]         slv_req_addr,
  output logic [DATA_W-1:0]         slv_req_wdata,
  output logic [DATA_W/8-1:0]       slv_req_wstrb,
  input  logic [N_SLV-1:0]          slv_rsp_valid,
  input  logic [N_SLV*DATA_W-1:0]   slv_rsp_rdata,
  output logic [ADDR_W-1:0]         err_addr
);

  localparam logic [TIMER_W-1:0] TMO = TIMER_W'(TIMEOUT);

  state_t               state;
  logic [N_SLV-1:0]     sel_q;
  logic [TIMER_W-1:0]   timer;
  logic [N_SLV-1:0]     dec_sel;
  logic                 dec_hit;
  logic                 sel_req_ready;
  logic                 sel_rsp_valid;
  logic [DATA_W-1:0]    sel_rdata;

  mmio_addr_dec #(
    .ADDR_W   (ADDR_W),
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (cpu_req_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Only the latched selected slave is ever listened to; everything else is ignored.
  always_comb begin
    sel_req_ready = 1'b0;
    sel_rsp_valid = 1'b0;
    sel_rdata     = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) begin
        sel_req_ready = sel_req_ready | slv_req_ready[i];
        sel_rsp_valid = sel_rsp_valid | slv_rsp_valid[i];
        sel_rdata     = sel_rdata | slv_rsp_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cpu_req_ready <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      cpu_rsp_err   <= 1'b0;
      slv_req_valid <= '0;
      slv_req_wen   <= 1'b0;
      slv_req_addr  <= '0;
      slv_req_wdata <= '0;
      slv_req_wstrb <= '0;
      err_addr      <= '0;
      sel_q         <= '0;
      timer         <= '0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cpu_req_ready <= 1'b1;
          if (cpu_req_valid && cpu_req_ready) begin
            cpu_req_ready <= 1'b0;
            slv_req_wen   <= cpu_req_wen;
            slv_req_addr  <= cpu_req_addr;
            slv_req_wdata <= cpu_req_wdata;
            slv_req_wstrb <= cpu_req_wstrb;
            sel_q         <= dec_sel;
            timer         <= '0;
            if (dec_hit) begin
              slv_req_valid <= dec_sel;
              state         <= ISSUE;
            end else begin
              cpu_rsp_valid <= 1'b1;
              cpu_rsp_err   <= 1'b1;
              cpu_rsp_rdata <= '0;
              err_addr      <= cpu_req_addr;
              state         <= RESP;
            end
          end
        end
        ISSUE: begin
          if (sel_req_ready) begin
            slv_req_valid <= '0;
            timer         <= '0;
            state         <= WAIT;
          end else if (timer == TMO) begin
            slv_req_valid <= '0;
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_err   <= 1'b1;
            cpu_rsp_rdata <= '0;
            err_addr      <= slv_req_addr;
            state         <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT: begin
          if (sel_rsp_valid) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_err   <= 1'b0;
            cpu_rsp_rdata <= slv_req_wen ? '0 : sel_rdata;
            state         <= RESP;
          end else if (timer == TMO) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_err   <= 1'b1;
            cpu_rsp_rdata <= '0;
            err_addr      <= slv_req_addr;
            state         <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed table-driven bench for mmio_router with a cycle-level slave model,
// plus a hand-written async-reset sequence.
module tb_mmio_router;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int N_SLV  = 4;
  localparam int NVEC   = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic                    cpu_req_wen;
  logic [ADDR_W-1:0]       cpu_req_addr;
  logic [DATA_W-1:0]       cpu_req_wdata;
  logic [DATA_W/8-1:0]     cpu_req_wstrb;
  logic                    cpu_rsp_valid;
  logic [DATA_W-1:0]       cpu_rsp_rdata;
  logic                    cpu_rsp_err;
  logic [N_SLV-1:0]        slv_req_valid;
  logic [N_SLV-1:0]        slv_req_ready;
  logic                    slv_req_wen;
  logic [ADDR_W-1:0]       slv_req_addr;
  logic [DATA_W-1:0]       slv_req_wdata;
  logic [DATA_W/8-1:0]     slv_req_wstrb;
  logic [N_SLV-1:0]        slv_rsp_valid;
  logic [N_SLV*DATA_W-1:0] slv_rsp_rdata;
  logic [ADDR_W-1:0]       err_addr;

  // Slave 3 sits inside slave 0's window, so slave 0 must always win there.
  mmio_router #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_SLV    (N_SLV),
    .SLV_BASE ({32'hB000_0000, 32'hC000_0000, 32'hA000_0000, 32'hB000_0000}),
    .SLV_MASK ({32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}),
    .TIMEOUT  (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_wen   (cpu_req_wen),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wstrb (cpu_req_wstrb),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .cpu_rsp_err   (cpu_rsp_err),
    .slv_req_valid (slv_req_valid),
    .slv_req_ready (slv_req_ready),
    .slv_req_wen   (slv_req_wen),
    .slv_req_addr  (slv_req_addr),
    .slv_req_wdata (slv_req_wdata),
    .slv_req_wstrb (slv_req_wstrb),
    .slv_rsp_valid (slv_rsp_valid),
    .slv_rsp_rdata (slv_rsp_rdata),
    .err_addr      (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         wen;
    logic [31:0]  addr;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    int           tgt;
    int           ready_delay;
    int           rsp_delay;
    int           stray;
    logic [63:0]  slv_rdata;
    int           exp_cycle;
    logic [63:0]  exp_rdata;
    logic         exp_err;
    logic [3:0]   exp_seen;
    logic [31:0]  exp_err_addr;
  } txn_vec_t;

  txn_vec_t vecs [NVEC];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic txn_vec_t make_vec(
    input string name, input logic wen, input logic [31:0] addr,
    input logic [63:0] wdata, input logic [7:0] wstrb, input int tgt,
    input int ready_delay, input int rsp_delay, input int stray,
    input logic [63:0] slv_rdata, input int exp_cycle, input logic [63:0] exp_rdata,
    input logic exp_err, input logic [3:0] exp_seen, input logic [31:0] exp_err_addr);
    txn_vec_t v;
    v.name = name;           v.wen = wen;               v.addr = addr;
    v.wdata = wdata;         v.wstrb = wstrb;           v.tgt = tgt;
    v.ready_delay = ready_delay; v.rsp_delay = rsp_delay; v.stray = stray;
    v.slv_rdata = slv_rdata; v.exp_cycle = exp_cycle;   v.exp_rdata = exp_rdata;
    v.exp_err = exp_err;     v.exp_seen = exp_seen;     v.exp_err_addr = exp_err_addr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one CPU request and act as the target slave cycle by cycle; cycle 0 is the accept edge.
  task automatic applyStimulus(input txn_vec_t v);
    int          rsp_cyc = -1;
    int          pulse = 0;
    int          issue_cnt = 0;
    int          wait_cnt = 0;
    int          fields_bad = 0;
    int          req_in_rsp = 0;
    logic        in_wait = 1'b0;
    logic        ready_after = 1'b0;
    logic [3:0]  seen = '0;
    logic [63:0] got_rdata = '0;
    logic        got_err = 1'b0;

    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_wen   = v.wen;
    cpu_req_addr  = v.addr;
    cpu_req_wdata = v.wdata;
    cpu_req_wstrb = v.wstrb;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      cpu_req_valid = 1'b0;
      seen = seen | slv_req_valid;
      if (cpu_rsp_valid) begin
        pulse++;
        if (rsp_cyc < 0) begin
          rsp_cyc   = cyc;
          got_rdata = cpu_rsp_rdata;
          got_err   = cpu_rsp_err;
          if (slv_req_valid != '0) req_in_rsp++;
        end
      end else if (rsp_cyc >= 0) begin
        ready_after = cpu_req_ready;
        break;
      end
      if (slv_req_valid != '0 &&
          (slv_req_wen !== v.wen || slv_req_addr !== v.addr ||
           slv_req_wdata !== v.wdata || slv_req_wstrb !== v.wstrb))
        fields_bad++;

      // Non-target slaves are always ready, so a wrong select would handshake early.
      slv_rsp_valid = '0;
      slv_rsp_rdata = '0;
      slv_req_ready = '1;
      if (v.tgt >= 0) begin
        slv_req_ready[v.tgt] = 1'b0;
        if (in_wait) begin
          if (wait_cnt == v.rsp_delay) begin
            slv_rsp_valid[v.tgt] = 1'b1;
            slv_rsp_rdata[v.tgt*DATA_W +: DATA_W] = v.slv_rdata;
            in_wait = 1'b0;
          end else if (v.stray >= 0) begin
            slv_rsp_valid[v.stray] = 1'b1;
            slv_rsp_rdata[v.stray*DATA_W +: DATA_W] = ~v.slv_rdata;
          end
          wait_cnt++;
        end
        if (slv_req_valid[v.tgt]) begin
          if (issue_cnt >= v.ready_delay) begin
            slv_req_ready[v.tgt] = 1'b1;
            in_wait = 1'b1;
          end
          issue_cnt++;
        end
      end
    end
    slv_req_ready = '0;
    slv_rsp_valid = '0;
    slv_rsp_rdata = '0;

    checkOutput({v.name, ".rsp_cycle"}, 64'(rsp_cyc), 64'(v.exp_cycle));
    checkOutput({v.name, ".rdata"}, got_rdata, v.exp_rdata);
    checkOutput({v.name, ".err"}, 64'(got_err), 64'(v.exp_err));
    checkOutput({v.name, ".req_valid_seen"}, 64'(seen), 64'(v.exp_seen));
    checkOutput({v.name, ".err_addr"}, 64'(err_addr), 64'(v.exp_err_addr));
    checkOutput({v.name, ".fields_unstable"}, 64'(fields_bad), 64'd0);
    checkOutput({v.name, ".req_valid_in_rsp"}, 64'(req_in_rsp), 64'd0);
    checkOutput({v.name, ".rsp_pulse_len"}, 64'(pulse), 64'd1);
    checkOutput({v.name, ".ready_after_rsp"}, 64'(ready_after), 64'd1);
  endtask

  initial begin
    int rsp_after_reset;

    vecs[0] = make_vec("map_rd", 1'b0, 32'hA000_0010, 64'h0, 8'h00, 1, 0, 0, -1,
                       64'h1234, 3, 64'h1234, 1'b0, 4'b0010, 32'h0);
    vecs[1] = make_vec("unmapped_rd", 1'b0, 32'h0000_0004, 64'h0, 8'h00, -1, 0, 0, -1,
                       64'h0, 1, 64'h0, 1'b1, 4'b0000, 32'h0000_0004);
    vecs[2] = make_vec("wr_backpressure", 1'b1, 32'hA000_0020, 64'hDEAD_BEEF, 8'h0F, 1, 3, 0, -1,
                       64'hFFFF, 6, 64'h0, 1'b0, 4'b0010, 32'h0000_0004);
    vecs[3] = make_vec("overlap_stray", 1'b0, 32'hB000_0040, 64'h0, 8'h00, 0, 0, 1, 3,
                       64'h5555_AAAA, 4, 64'h5555_AAAA, 1'b0, 4'b0001, 32'h0000_0004);
    vecs[4] = make_vec("timeout", 1'b0, 32'hC000_0008, 64'h0, 8'h00, 2, 1000, 0, -1,
                       64'h77, 10, 64'h0, 1'b1, 4'b0100, 32'hC000_0008);
    vecs[5] = make_vec("rd_slv0", 1'b0, 32'hB000_1000, 64'h0, 8'h00, 0, 0, 0, -1,
                       64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF, 1'b0, 4'b0001, 32'hC000_0008);
    vecs[6] = make_vec("wr_zero_strb", 1'b1, 32'hC000_0000, 64'h1122_3344, 8'h00, 2, 0, 0, -1,
                       64'h99, 3, 64'h0, 1'b0, 4'b0100, 32'hC000_0008);
    vecs[7] = make_vec("unmapped_wr", 1'b1, 32'hA000_1000, 64'hABCD, 8'hFF, -1, 0, 0, -1,
                       64'h0, 1, 64'h0, 1'b1, 4'b0000, 32'hA000_1000);

    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_wen   = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    cpu_req_wstrb = '0;
    slv_req_ready = '0;
    slv_rsp_valid = '0;
    slv_rsp_rdata = '0;
    #1;
    checkOutput("reset.rsp_valid", 64'(cpu_rsp_valid), 64'd0);
    checkOutput("reset.req_valid", 64'(slv_req_valid), 64'd0);
    checkOutput("reset.err_addr", 64'(err_addr), 64'd0);
    checkOutput("reset.rsp_err", 64'(cpu_rsp_err), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ready_after_release", 64'(cpu_req_ready), 64'd1);

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

    // Async reset while waiting for a slave response.
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_wen   = 1'b0;
    cpu_req_addr  = 32'hA000_0010;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    checkOutput("async_rst.issue_valid", 64'(slv_req_valid), 64'b0010);
    slv_req_ready = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    slv_req_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst.req_valid", 64'(slv_req_valid), 64'd0);
    checkOutput("async_rst.rsp_valid", 64'(cpu_rsp_valid), 64'd0);
    checkOutput("async_rst.err_addr", 64'(err_addr), 64'd0);
    checkOutput("async_rst.req_addr", 64'(slv_req_addr), 64'd0);
    slv_rsp_valid = 4'b0010;
    slv_rsp_rdata[DATA_W +: DATA_W] = 64'hCAFE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    slv_rsp_valid = '0;
    slv_rsp_rdata = '0;
    rsp_after_reset = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_rsp_valid) rsp_after_reset++;
      if (c == 0) checkOutput("async_rst.ready_after_release", 64'(cpu_req_ready), 64'd1);
    end
    checkOutput("async_rst.no_rsp_after_release", 64'(rsp_after_reset), 64'd0);

    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_router.md
Name: mmio_router

Overview:
- Parametrised memory-mapped I/O router between the CPU LSU port and N_SLV peripheral slaves (RAM, keyboard, switches, RTC, seg, LED, and so on).
- Replaces fixed-address combinational decode with a configurable address map.
- Uses a valid/ready request handshake, registered responses, and one outstanding transaction.
- Returns an error response for unmapped addresses and for slaves that time out.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; must be a multiple of 8.
- N_SLV, 4, number of slave channels (1..16).
- SLV_BASE, {N_SLV{ADDR_W'h0}}, packed base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {N_SLV{ADDR_W'h0}}, packed match masks; slave i hits when (addr & mask_i) == (base_i & mask_i).
- TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before an error response; 8-bit counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  request valid.
- cpu_req_ready  out  1  router can accept a request.
- cpu_req_wen  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W  byte address.
- cpu_req_wdata  in  DATA_W  write data.
- cpu_req_wstrb  in  DATA_W/8  byte write enables.
- cpu_rsp_valid  out  1  one-cycle response pulse.
- cpu_rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- cpu_rsp_err  out  1  unmapped address or timeout.
- slv_req_valid  out  N_SLV  one-hot request to the selected slave.
- slv_req_ready  in  N_SLV  per-slave accept.
- slv_req_wen  out  1  shared, registered.
- slv_req_addr  out  ADDR_W  shared, registered full address.
- slv_req_wdata  out  DATA_W  shared, registered.
- slv_req_wstrb  out  DATA_W/8  shared, registered.
- slv_rsp_valid  in  N_SLV  per-slave response/ack pulse.
- slv_rsp_rdata  in  N_SLV*DATA_W  packed per-slave read data.
- err_addr  out  ADDR_W  address of the most recent errored request; sticky.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. cpu_req_ready=1 once released. All other outputs 0, including err_addr. Timer 0.
- Reset mid-transaction: transaction dropped, no response issued, slv_req_valid deasserted immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid: register wen/addr/wdata/wstrb and the decoded one-hot select.
  - Hit → ISSUE.
  - No hit → RESP with err=1, err_addr<=addr.
- Decode priority: when several slaves match, the lowest index wins.
- ISSUE:
  - slv_req_valid[sel]=1.
  - On slv_req_ready[sel] → WAIT, timer cleared.
  - Request fields stay stable while valid and not ready.
- WAIT:
  - On slv_rsp_valid[sel]: latch rdata (0 if write), err=0 → RESP.
  - slv_rsp_valid is sampled only in WAIT and only from sel; all other rsp_valid bits are ignored.
- Timer: increments every cycle in ISSUE and WAIT; cleared on entering ISSUE and on the ISSUE→WAIT handshake. When timer==TIMEOUT with no progress → RESP with err=1, rdata=0, err_addr<=addr, slv_req_valid dropped.
- RESP:
  - cpu_rsp_valid=1 for exactly one cycle with registered rdata/err → IDLE.
  - The CPU always accepts the response; there is no rsp_ready.
  - cpu_req_ready=0 in ISSUE, WAIT and RESP.
- Latency:
  - Unmapped: request accepted in cycle 0, rsp_valid in cycle 1.
  - Mapped, zero-wait slave: accept c0, ISSUE handshake c1, slave rsp c2, cpu_rsp_valid c3.
- Back-to-back: a new request may be accepted in the cycle after RESP (IDLE); no overlap.
- Width rules:
  - Read data is passed unmodified.
  - Sub-word extraction and sign-extension are the LSU's job.
  - wstrb is forwarded unmodified; an all-zero wstrb write still issues and needs an ack.

Decomposition:
- Package mmio_pkg:
  - state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - default address-map constants (ADDR_RAM/RAM_LEN, KBD_ADDR/KBD_LEN, SWT_ADDR, SEG_ADDR, LED_ADDR, PERI_LEN, RTC_ADDR/RTC_LEN) expressed as base/mask pairs.
  - TIMEOUT width constant.
- Sub-module mmio_addr_dec: purely combinational priority decoder (addr, SLV_BASE, SLV_MASK) → one-hot sel[N_SLV] plus hit. The router instantiates it once.

Test Plan:
- Mapped read, zero-wait: N_SLV=4, slave1 base 0xA000_0000 mask 0xFFFF_F000, read 0xA000_0010; slave readies immediately and returns 0x1234 the next cycle → cpu_rsp_valid at c3, rdata=0x1234, err=0, only slv_req_valid[1] ever asserted.
- Unmapped read: read 0x0000_0004 → rsp at c1, err=1, rdata=0, err_addr=0x0000_0004, no slv_req_valid.
- Timeout: TIMEOUT=8, slave2 never asserts ready → err response after 8 ISSUE cycles, slv_req_valid[2] dropped, then a new request is accepted.
- Write with backpressure: write wdata=0xDEAD_BEEF, wstrb=0x0F; ready held low 3 cycles → request fields stable throughout, ack produces rsp with rdata=0, err=0.
- Overlap and stray responses: slaves 0 and 3 both match an address → slave 0 is selected; a stray slv_rsp_valid[3] during WAIT is ignored.
- Async reset: assert rst_n=0 in WAIT mid-cycle → all outputs 0 immediately, no cpu_rsp_valid after release, cpu_req_ready=1 after release.
